leaky_relu_backward: RTL and testbench

Backward (gradient) pass of the fixed-point leaky ReLU activation. It joins two lock-stepped streams: the saved forward input `x` and the upstream gradient `dy`. It emits `dx = dy` for lanes where `x > 0`, and `dx = (dy * ALPHA_INT) >>> ALPHA_FRAC` otherwise. It sits in the training datapath directly after the gradient source of the next layer. It uses a registered two-stage pipeline, a beat counter, and a tensor-end flag.

---
 rtl/leaky_relu_backward_pkg.sv | 28 ++
 rtl/leaky_relu_backward_if.sv | 38 +++
 rtl/leaky_relu_backward_lane.sv | 32 +++
 rtl/leaky_relu_backward.sv | 141 ++++++++++++++
 tb/tb_leaky_relu_backward.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaky_relu_backward_pkg.sv
// leaky_relu_backward_pkg: shared sizing rules and helpers
// for the leaky ReLU gradient pipeline.
package leaky_relu_backward_pkg;

    localparam int SAT_W = 64;

    function automatic int beat_count(input int size, input int par);
        return size / par;
    endfunction

    function automatic int prod_width(input int grad_w, input int alpha_int);
        return grad_w + $clog2(alpha_int + 1) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/leaky_relu_backward_if.sv
// leaky_relu_backward_if: the x / dy input streams and the
// dx output stream with their valid/ready/last signals.
interface leaky_relu_backward_if #(
    parameter int XW = 8,
    parameter int GW = 8,
    parameter int OW = 8,
    parameter int N  = 2
);
    logic [N-1:0][XW-1:0] data_in_0;
    logic                 data_in_0_valid;
    logic                 data_in_0_ready;
    logic [N-1:0][GW-1:0] grad_out_0;
    logic                 grad_out_0_valid;
    logic                 grad_out_0_ready;
    logic [N-1:0][OW-1:0] data_out_0;
    logic                 data_out_0_valid;
    logic                 data_out_0_ready;
    logic                 data_out_0_last;

    modport master (
        output data_in_0, data_in_0_valid,
        input  data_in_0_ready,
        output grad_out_0, grad_out_0_valid,
        input  grad_out_0_ready,
        input  data_out_0, data_out_0_valid, data_out_0_last,
        output data_out_0_ready
    );

    modport slave (
        input  data_in_0, data_in_0_valid,
        output data_in_0_ready,
        input  grad_out_0, grad_out_0_valid,
        output grad_out_0_ready,
        output data_out_0, data_out_0_valid, data_out_0_last,
        input  data_out_0_ready
    );

endinterface

// File: rtl/leaky_relu_backward_lane.sv
// leaky_relu_backward_lane: one lane of dx = dy or
// floor(dy * alpha) with output saturation.
module leaky_relu_backward_lane
    import leaky_relu_backward_pkg::*;
#(
    parameter int GW         = 8,
    parameter int OW         = 8,
    parameter int ALPHA_INT  = 3,
    parameter int ALPHA_FRAC = 5
) (
    input  logic          mask,
    input  logic [GW-1:0] dy,
    output logic [OW-1:0] dx
);

    localparam int PW = prod_width(GW, ALPHA_INT);

    logic signed [PW-1:0]    dy_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    sel;
    logic signed [SAT_W-1:0] wide;

    // Scale by alpha on the masked path, floor-shift, then clamp.
    always_comb begin
        dy_ext = {{(PW-GW){dy[GW-1]}}, dy};
        prod   = dy_ext * PW'(ALPHA_INT);
        sel    = mask ? (prod >>> ALPHA_FRAC) : dy_ext;
        wide   = {{(SAT_W-PW){sel[PW-1]}}, sel};
        dx     = OW'(sat(wide, OW));
    end

endmodule

// File: rtl/leaky_relu_backward.sv
// leaky_relu_backward: joins x and dy streams, two-stage
// registered pipeline producing dx with a tensor-end flag.
module leaky_relu_backward
    import leaky_relu_backward_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 1,
    parameter int GRAD_OUT_0_PRECISION_0      = 8,
    parameter int GRAD_OUT_0_PRECISION_1      = 4,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int ALPHA_INT                   = 3,
    parameter int ALPHA_FRAC                  = 5,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 2,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
    input logic                 clk,
    input logic                 rst,
    leaky_relu_backward_if.slave io
);

    localparam int XW = DATA_IN_0_PRECISION_0;
    localparam int GW = GRAD_OUT_0_PRECISION_0;
    localparam int OW = DATA_OUT_0_PRECISION_0;
    localparam int N  = DATA_IN_0_PARALLELISM_DIM_0
                      * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int B  =
        beat_count(DATA_IN_0_TENSOR_SIZE_DIM_0,
                   DATA_IN_0_PARALLELISM_DIM_0) *
        beat_count(DATA_IN_0_TENSOR_SIZE_DIM_1,
                   DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    if (DATA_OUT_0_PRECISION_1 != GRAD_OUT_0_PRECISION_1) begin : g_frac_chk
        $error("dx and dy fractional bits must match");
    end
    if (DATA_IN_0_PRECISION_1 >= DATA_IN_0_PRECISION_0) begin : g_xfrac_chk
        $error("x fractional bits exceed x width");
    end
    if ((DATA_IN_0_TENSOR_SIZE_DIM_0 % DATA_IN_0_PARALLELISM_DIM_0 != 0) ||
        (DATA_IN_0_TENSOR_SIZE_DIM_1 % DATA_IN_0_PARALLELISM_DIM_1 != 0))
    begin : g_par_chk
        $error("parallelism must divide tensor size");
    end

    logic                 s1_valid;
    logic                 s1_last;
    logic [N-1:0]         s1_mask;
    logic [N-1:0][GW-1:0] s1_dy;
    logic                 s2_valid;
    logic                 s2_last;
    logic [N-1:0][OW-1:0] s2_dx;
    logic [N-1:0][OW-1:0] lane_dx;
    logic [CW-1:0]        beat;
    logic [N-1:0]         mask;
    logic                 s2_accept;
    logic                 s1_move;
    logic                 s1_accept;
    logic                 in_fire;
    logic                 beat_end;

    // Join handshake, stage-advance conditions and output drive.
    always_comb begin
        s2_accept           = !s2_valid || io.data_out_0_ready;
        s1_move             = s1_valid && s2_accept;
        s1_accept           = !s1_valid || s1_move;
        in_fire             = io.data_in_0_valid && io.grad_out_0_valid
                              && s1_accept && !rst;
        io.data_in_0_ready  = io.grad_out_0_valid && s1_accept && !rst;
        io.grad_out_0_ready = io.data_in_0_valid && s1_accept && !rst;
        io.data_out_0       = s2_dx;
        io.data_out_0_valid = s2_valid;
        io.data_out_0_last  = s2_last;
        beat_end            = (beat == CW'(B - 1));
    end

    // Per-lane select: x <= 0 (sign bit or exact zero) takes alpha.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = io.data_in_0[i][XW-1] || (io.data_in_0[i] == '0);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        leaky_relu_backward_lane #(
            .GW         (GW),
            .OW         (OW),
            .ALPHA_INT  (ALPHA_INT),
            .ALPHA_FRAC (ALPHA_FRAC)
        ) u_lane (
            .mask (s1_mask[g]),
            .dy   (s1_dy[g]),
            .dx   (lane_dx[g])
        );
    end

    // Beat position within the tensor, wrapping after B-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (in_fire) begin
            beat <= beat_end ? '0 : beat + 1'b1;
        end
    end

    // Stage 1: mask, dy and last flag of the accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mask  <= '0;
            s1_dy    <= '0;
        end else begin
            if (s1_accept) s1_valid <= in_fire;
            if (in_fire) begin
                s1_mask <= mask;
                s1_dy   <= io.grad_out_0;
                s1_last <= beat_end;
            end
        end
    end

    // Stage 2: saturated dx held until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_dx    <= '0;
        end else begin
            if (s2_accept) s2_valid <= s1_valid;
            if (s1_move) begin
                s2_dx   <= lane_dx;
                s2_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_leaky_relu_backward.sv
// tb_leaky_relu_backward: scoreboard bench for the leaky ReLU
// gradient pipeline (default build and a 6-bit output build).
module tb_leaky_relu_backward;

    typedef struct {
        logic [15:0] dx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   tb_beat = 0;
    int   pop_cyc[$];
    exp_t q[$];
    exp_t q6[$];
    logic rnd_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    leaky_relu_backward_if #(.XW(8), .GW(8), .OW(8), .N(2)) bus ();
    leaky_relu_backward_if #(.XW(8), .GW(8), .OW(6), .N(2)) bus6 ();

    leaky_relu_backward dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    leaky_relu_backward #(.DATA_OUT_0_PRECISION_0(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .io  (bus6)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int model(input int x, input int dy, input int w);
        int v;
        int p;
        int hi;
        v = dy;
        if (x <= 0) begin
            p = dy * 3;
            v = (p >= 0) ? p / 32 : -((-p + 31) / 32);
        end
        hi = (1 << (w - 1)) - 1;
        if (v > hi) v = hi;
        if (v < -hi - 1) v = -hi - 1;
        return v;
    endfunction

    // Main output monitor: scoreboard pop plus stall stability.
    logic        stall_prev = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stable",
                      {bus.data_out_0_last, bus.data_out_0_valid,
                       bus.data_out_0}, held);
            if (bus.data_out_0_valid && bus.data_out_0_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h want none",
                             bus.data_out_0);
                end else begin
                    e = q.pop_front();
                    check("dx_beat", {bus.data_out_0_last, bus.data_out_0},
                          {e.last, e.dx});
                    pop_cyc.push_back(cyc);
                end
            end
            stall_prev = bus.data_out_0_valid && !bus.data_out_0_ready;
            held = {bus.data_out_0_last, bus.data_out_0_valid,
                    bus.data_out_0};
        end
    end

    // Narrow-output monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus6.data_out_0_valid && bus6.data_out_0_ready) begin
            if (q6.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out6: got %0h want none",
                         bus6.data_out_0);
            end else begin
                e = q6.pop_front();
                check("dx6_beat", {bus6.data_out_0_last, bus6.data_out_0},
                      {e.last, e.dx[11:0]});
            end
        end
    end

    // Random output back-pressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) bus.data_out_0_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle();
        bus.data_in_0_valid  = 1'b0;
        bus.grad_out_0_valid = 1'b0;
    endtask

    task automatic send(input int x0, input int x1, input int d0,
                        input int d1, input int e0, input int e1);
        logic fired;
        exp_t e;
        bus.data_in_0        = {8'(x1), 8'(x0)};
        bus.grad_out_0       = {8'(d1), 8'(d0)};
        bus.data_in_0_valid  = 1'b1;
        bus.grad_out_0_valid = 1'b1;
        fired = 1'b0;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clk);
            fired = bus.data_in_0_ready && bus.grad_out_0_ready;
            if (fired) begin
                e.dx   = {8'(e1), 8'(e0)};
                e.last = (tb_beat == 3);
                q.push_back(e);
                tb_beat = (tb_beat + 1) % 4;
            end
            @(posedge clk);
            #1;
        end
        if (!fired) check("send_timeout", 0, 1);
    endtask

    task automatic send6(input int x0, input int x1, input int d0,
                         input int d1, input int e0, input int e1,
                         input logic last);
        logic fired;
        exp_t e;
        bus6.data_in_0        = {8'(x1), 8'(x0)};
        bus6.grad_out_0       = {8'(d1), 8'(d0)};
        bus6.data_in_0_valid  = 1'b1;
        bus6.grad_out_0_valid = 1'b1;
        fired = 1'b0;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clk);
            fired = bus6.data_in_0_ready && bus6.grad_out_0_ready;
            if (fired) begin
                e.dx   = {4'd0, 6'(e1), 6'(e0)};
                e.last = last;
                q6.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus6.data_in_0_valid  = 1'b0;
        bus6.grad_out_0_valid = 1'b0;
        if (!fired) check("send6_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q.size() != 0 || q6.size() != 0); i++)
            @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc0;
        int x0;
        int x1;
        int d0;
        int d1;
        rst = 1'b1;
        bus.data_in_0 = '0;
        bus.grad_out_0 = '0;
        bus.data_in_0_valid = 1'b1;
        bus.grad_out_0_valid = 1'b1;
        bus.data_out_0_ready = 1'b0;
        bus6.data_in_0 = '0;
        bus6.grad_out_0 = '0;
        bus6.data_in_0_valid = 1'b0;
        bus6.grad_out_0_valid = 1'b0;
        bus6.data_out_0_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.data_out_0_valid, 0);
        check("rst_last", bus.data_out_0_last, 0);
        check("rst_data", bus.data_out_0, 0);
        check("rst_x_ready", bus.data_in_0_ready, 0);
        check("rst_dy_ready", bus.grad_out_0_ready, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        bus.data_out_0_ready = 1'b1;
        @(posedge clk);
        #1;

        // Sign select with latency probe.
        send(5, -5, 64, 64, 64, 6);
        idle();
        check("lat_edge1", bus.data_out_0_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2", bus.data_out_0_valid, 1);
        send(0, 1, -64, -64, -6, -64);
        // Floor rounding.
        send(1, -1, 7, -1, 7, -1);
        send(-1, -1, 10, -128, 0, -12);
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Only one input stream valid.
        bus.grad_out_0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("join_dy_ready", bus.grad_out_0_ready, 0);
            check("join_x_ready", bus.data_in_0_ready, 1);
        end
        idle();
        bus.data_in_0_valid = 1'b1;
        @(negedge clk);
        check("join_x_only", bus.data_in_0_ready, 0);
        @(posedge clk);
        #1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("join_no_out", bus.data_out_0_valid, 0);

        // Back-to-back burst of 12 beats.
        pc0 = pop_cyc.size();
        for (int i = 0; i < 12; i++) begin
            x0 = i - 5;
            x1 = 5 - i;
            d0 = i * 20 - 110;
            d1 = 115 - i * 19;
            send(x0, x1, d0, d1, model(x0, d0, 8), model(x1, d1, 8));
        end
        idle();
        drain();
        repeat (2) @(posedge clk);
        #1;
        if (pop_cyc.size() >= pc0 + 12)
            check("burst_rate", pop_cyc[pc0+11] - pop_cyc[pc0], 11);
        else
            check("burst_count", pop_cyc.size() - pc0, 12);

        // Random output back-pressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x0 = int'($urandom_range(0, 255)) - 128;
            x1 = int'($urandom_range(0, 255)) - 128;
            d0 = int'($urandom_range(0, 255)) - 128;
            d1 = int'($urandom_range(0, 255)) - 128;
            send(x0, x1, d0, d1, model(x0, d0, 8), model(x1, d1, 8));
        end
        idle();
        rnd_en = 1'b0;
        #1;
        bus.data_out_0_ready = 1'b1;
        drain();

        // Reset with the pipe full.
        bus.data_out_0_ready = 1'b0;
        send(3, 3, 10, 20, 10, 20);
        send(4, 4, 30, 40, 30, 40);
        idle();
        @(posedge clk);
        #1;
        check("full_x_ready", bus.data_in_0_ready, 0);
        check("full_valid", bus.data_out_0_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", bus.data_out_0_valid, 0);
        check("async_rst_last", bus.data_out_0_last, 0);
        q.delete();
        tb_beat = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_out_0_ready = 1'b1;
        send(2, -2, 16, 32, 16, 3);
        send(-3, 3, -32, 48, -3, 48);
        send(9, -9, 100, 100, 100, 9);
        send(-7, 7, -100, -100, -10, -100);
        idle();
        drain();

        // Saturation on the 6-bit output build.
        send6(3, 3, 100, -100, 31, -32, 1'b0);
        send6(-3, -3, 100, -100, 9, -10, 1'b0);
        drain();

        check("sb_empty", q.size(), 0);
        check("sb6_empty", q6.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
